// File: rtl/muldiv_if.sv
// Bundle of the EX-stage request, HI/LO write and result signals for the
// iterative multiply/divide unit; the pipeline drives it as master.
interface muldiv_if;
    // Request handshake: start is a valid strobe and ~busy is ready. A request
    // transfers on a rising edge where start=1 and busy=0; op/a/b are sampled
    // only at that edge. done pulses for one cycle when HI/LO hold the result.
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  state_dbg;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wr_data,
        input  busy, done, div_by_zero, hi, lo, state_dbg
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wr_data,
        output busy, done, div_by_zero, hi, lo, state_dbg
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide with a fixed 34-cycle latency.
// Owns the architectural HI/LO registers and the mthi/mtlo write path.
module muldiv_unit (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        b_zero;
    logic [31:0] a_orig;
    logic [31:0] opnd;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;
    logic        dbz_q;

    // Operand preparation at issue: signs for signed ops, magnitudes as unsigned.
    logic        in_signed;
    logic        in_sa;
    logic        in_sb;
    logic [31:0] in_abs_a;
    logic [31:0] in_abs_b;

    always_comb begin
        in_signed = ~bus.op[0];
        in_sa     = in_signed & bus.a[31];
        in_sb     = in_signed & bus.b[31];
        in_abs_a  = in_sa ? (~bus.a + 32'd1) : bus.a;
        in_abs_b  = in_sb ? (~bus.b + 32'd1) : bus.b;
    end

    // One iteration. Multiply: acc_lo holds the remaining multiplier bits and
    // collects product low bits as the sum shifts right. Divide: acc_lo holds
    // dividend bits shifted out MSB first and collects quotient bits.
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [31:0] acc_hi_n;
    logic [31:0] acc_lo_n;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
        div_shift = {acc_hi, acc_lo[31]};
        div_diff  = div_shift - {1'b0, opnd};
        acc_hi_n  = acc_hi;
        acc_lo_n  = acc_lo;
        if (is_div) begin
            if (!div_diff[32]) begin
                acc_hi_n = div_diff[31:0];
                acc_lo_n = {acc_lo[30:0], 1'b1};
            end else begin
                acc_hi_n = div_shift[31:0];
                acc_lo_n = {acc_lo[30:0], 1'b0};
            end
        end else begin
            acc_hi_n = mul_sum[32:1];
            acc_lo_n = {mul_sum[0], acc_lo[31:1]};
        end
    end

    // Sign fix-up and the divide-by-zero override.
    logic [63:0] product;
    logic [63:0] product_fix;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    always_comb begin
        product     = {acc_hi, acc_lo};
        product_fix = neg_res ? (~product + 64'd1) : product;
        fix_hi      = product_fix[63:32];
        fix_lo      = product_fix[31:0];
        if (is_div) begin
            if (b_zero) begin
                fix_hi = a_orig;
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                fix_hi = neg_rem ? (~acc_hi + 32'd1) : acc_hi;
                fix_lo = neg_res ? (~acc_lo + 32'd1) : acc_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 6'd0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            a_orig  <= 32'd0;
            opnd    <= 32'd0;
            acc_hi  <= 32'd0;
            acc_lo  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.wr_hi) hi_q <= bus.wr_data;
                    if (bus.wr_lo) lo_q <= bus.wr_data;
                    if (bus.start) begin
                        is_div  <= bus.op[1];
                        neg_res <= in_sa ^ in_sb;
                        neg_rem <= in_sa;
                        b_zero  <= (bus.b == 32'd0);
                        a_orig  <= bus.a;
                        opnd    <= bus.op[1] ? in_abs_b : in_abs_a;
                        acc_hi  <= 32'd0;
                        acc_lo  <= bus.op[1] ? in_abs_a : in_abs_b;
                        cnt     <= 6'd0;
                        state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_hi <= acc_hi_n;
                    acc_lo <= acc_lo_n;
                    cnt    <= cnt + 6'd1;
                    if (cnt == 6'd31) state <= S_FIX;
                end
                S_FIX: begin
                    hi_q   <= fix_hi;
                    lo_q   <= fix_lo;
                    done_q <= 1'b1;
                    dbz_q  <= is_div & b_zero;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vectors, hand-written pipeline-interaction
// sequences and random operations against an arithmetic reference model.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_if bus();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [64:0] exp_q[$];
    logic done_prev = 1'b0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Result {div_by_zero, hi, lo} computed from plain 64-bit arithmetic.
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, up;
        logic [63:0] qv, rv;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'd0: begin
                up = sa * sb;
                return {1'b0, up};
            end
            2'd1: begin
                up = ua * ub;
                return {1'b0, up};
            end
            2'd2: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                qv = q;
                rv = r;
                return {1'b0, rv[31:0], qv[31:0]};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                qv = ua / ub;
                rv = ua % ub;
                return {1'b0, rv[31:0], qv[31:0]};
            end
        endcase
    endfunction

    // Scoreboard: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst) begin
            done_prev <= 1'b0;
        end else begin
            check("done_single_cycle", {64'd0, bus.done & done_prev}, 65'd0);
            check("dbz_only_with_done", {64'd0, bus.div_by_zero & ~bus.done}, 65'd0);
            if (bus.done) begin
                check("done_expected", {64'd0, exp_q.size() != 0}, 65'd1);
                if (exp_q.size() != 0)
                    check("result", {bus.div_by_zero, bus.hi, bus.lo}, exp_q.pop_front());
            end
            done_prev <= bus.done;
        end
    end

    // Called #1 after an edge; the request is accepted on the next edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom_range(0, 3));
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic wait_done(input int exp_lat, input string name);
        int cnt = 0;
        int busy_n = 0;
        while (!bus.done && cnt < 40) begin
            if (bus.busy) busy_n++;
            @(posedge clk); #1;
            cnt++;
        end
        check({name, "_latency"}, cnt, exp_lat);
        check({name, "_busy_cycles"}, busy_n, exp_lat);
        check({name, "_busy_low_at_done"}, {64'd0, bus.busy}, 65'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corner [5];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        logic [64:0] e1, e2;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        vecs[0] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[3] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5] = '{2'd3, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[7] = '{2'd2, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
        vecs[8] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
        vecs[9] = '{2'd0, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};

        // Reset with start and writes asserted: all must be ignored.
        rst = 1'b1;
        bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd3; bus.b = 32'd4;
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.start = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        check("reset_hi", {33'd0, bus.hi}, 65'd0);
        check("reset_lo", {33'd0, bus.lo}, 65'd0);
        check("reset_busy", {64'd0, bus.busy}, 65'd0);
        check("reset_done", {64'd0, bus.done}, 65'd0);
        check("reset_dbz", {64'd0, bus.div_by_zero}, 65'd0);
        @(posedge clk); #1;
        check("start_in_reset_ignored", {64'd0, bus.busy}, 65'd0);

        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({vecs[i].dbz, vecs[i].hi, vecs[i].lo});
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(33, "vec");
        end

        // Second start during cycle 5 of an operation is ignored.
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 32'h0000_0000, 32'h0000_0048});
        issue(2'd1, 32'd8, 32'd9);
        repeat (4) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.op = 2'd2; bus.a = 32'd100; bus.b = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(28, "ignored_start");
        repeat (40) begin @(posedge clk); #1; end

        // mthi/mtlo while busy are dropped; the result stands.
        exp_q.push_back({1'b0, 32'h0000_0000, 32'h0000_002A});
        issue(2'd0, 32'd6, 32'd7);
        repeat (3) begin @(posedge clk); #1; end
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        wait_done(29, "wr_while_busy");
        @(posedge clk); #1;

        // mthi in IDLE lands on the next edge.
        bus.wr_hi = 1'b1; bus.wr_data = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        bus.wr_hi = 1'b0;
        check("mthi_idle_hi", {33'd0, bus.hi}, {33'd0, 32'hA5A5_A5A5});
        check("mthi_idle_lo_kept", {33'd0, bus.lo}, {33'd0, 32'h0000_002A});
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'h0F0F_0F0F;
        @(posedge clk); #1;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        check("mthi_mtlo_both", {1'b0, bus.hi, bus.lo}, {1'b0, 32'h0F0F_0F0F, 32'h0F0F_0F0F});

        // Write and start on the same edge: write first, result later.
        bus.wr_hi = 1'b1; bus.wr_data = 32'h1111_1111;
        exp_q.push_back({1'b0, 32'h0000_0000, 32'h0000_0006});
        issue(2'd1, 32'd2, 32'd3);
        bus.wr_hi = 1'b0;
        check("wr_with_start", {1'b0, bus.hi, bus.lo}, {1'b0, 32'h1111_1111, 32'h0F0F_0F0F});
        wait_done(33, "wr_with_start");

        // Back-to-back: second start accepted on the done cycle.
        @(posedge clk); #1;
        e1 = model(2'd2, 32'hFFFF_FF9C, 32'h0000_0007);
        e2 = model(2'd0, 32'h0001_0000, 32'hFFFF_0000);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        issue(2'd2, 32'hFFFF_FF9C, 32'h0000_0007);
        wait_done(33, "b2b_first");
        issue(2'd0, 32'h0001_0000, 32'hFFFF_0000);
        check("b2b_second_accepted", {64'd0, bus.busy}, 65'd1);
        repeat (10) begin @(posedge clk); #1; end
        check("b2b_hilo_held", {1'b0, bus.hi, bus.lo}, {1'b0, e1[63:0]});
        wait_done(23, "b2b_second");

        // Reset at cycle 10 of a mult aborts it without a result.
        @(posedge clk); #1;
        issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_hilo", {1'b0, bus.hi, bus.lo}, 65'd0);
        check("abort_busy", {64'd0, bus.busy}, 65'd0);
        check("abort_done", {64'd0, bus.done}, 65'd0);
        repeat (40) begin @(posedge clk); #1; end
        exp_q.push_back({1'b0, 32'h0000_0000, 32'h0000_000C});
        issue(2'd1, 32'd3, 32'd4);
        wait_done(33, "after_abort");

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick_operand();
            rb  = pick_operand();
            exp_q.push_back(model(rop, ra, rb));
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
            issue(rop, ra, rb);
            wait_done(33, "random");
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 65'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. It executes mult, multu, div and divu over a fixed 34-cycle latency and owns the architectural HI/LO registers. It also accepts mthi/mtlo writes. It raises Busy so the hazard logic can stall IF/ID/EX while an operation is in flight, and the HI/LO outputs feed the EX-stage ALU for mfhi/mflo.

## Interface
- No parameters; datapath width fixed at 32 bits.
- Clk  input  1  pipeline clock; all state changes on rising edge.
- Rst  input  1  synchronous, active-high reset; highest priority.
- Start  input  1  launch operation; sampled only when Busy=0.
- Op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with Start.
- A  input  32  rs operand (multiplicand / dividend); sampled with Start.
- B  input  32  rt operand (multiplier / divisor); sampled with Start.
- WrHi  input  1  mthi write enable.
- WrLo  input  1  mtlo write enable.
- WrData  input  32  mthi/mtlo data.
- Busy  output  1  operation in flight (state != IDLE).
- Done  output  1  one-cycle pulse: HI/LO hold the new result.
- DivByZero  output  1  one-cycle pulse coincident with Done for div/divu with B=0.
- HI  output  32  HI register.
- LO  output  32  LO register.

## Operation
- States: IDLE, CALC, FIX. Busy = (state != IDLE).
- IDLE with Start=1:
  - Latch Op.
  - Latch sign bits sA=A[31] and sB=B[31] for signed ops; 0 for unsigned ops.
  - Latch magnitudes |A| and |B| as 32-bit unsigned. 0x80000000 stays 0x80000000.
  - Clear the 6-bit iteration counter and go to CALC.
- CALC, multiply:
  - Radix-2 shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- CALC, divide:
  - Restoring division, one quotient bit per cycle, MSB first.
  - 33-bit partial-remainder subtract.
- CALC exit: after 32 iterations (counter = 31 on that edge), go to FIX.
- FIX, multiply: {HI,LO} = (sA^sB) ? -product : product, 64-bit two's complement.
- FIX, divide, B!=0:
  - LO = quotient, negated if sA^sB.
  - HI = remainder, negated if sA.
  - 0x80000000 / 0xFFFFFFFF (div) yields LO=0x80000000, HI=0. No trap.
- FIX, divide, B=0:
  - HI = original A and LO = 0xFFFFFFFF for both div and divu.
  - DivByZero pulses.
- FIX exit: assert Done for the next cycle and return to IDLE.
- Start while Busy=1 is ignored. Op/A/B changes during CALC/FIX have no effect.
- WrHi/WrLo apply only when state=IDLE; they are ignored while Busy, since the pipeline stalls the instruction. WrHi and WrLo together write WrData to both registers.
- Start and WrHi/WrLo in the same IDLE cycle: the write lands on that edge, and the operation result overwrites HI/LO later.
- Rst:
  - HI=0, LO=0, Busy=0, Done=0, DivByZero=0, state=IDLE, counter=0.
  - Reset mid-operation aborts it with no result written.
  - Start or Wr* during Rst is ignored.

## Timing
- Start sampled at edge k gives:
  - Busy=1 from after edge k through edge k+33.
  - CALC iterations on edges k+1..k+32.
  - FIX on edge k+33: HI/LO updated, Done=1 and DivByZero (if any) asserted for one cycle, Busy=0.
- Issue-to-result latency is 34 cycles and independent of operand values, including B=0.
- Back-to-back: Start asserted in the Done cycle is accepted at that edge. HI/LO keep the previous result until the new FIX.
- HI/LO are registered outputs, stable except on a FIX edge, an accepted Wr* edge, or Rst.
- Done and DivByZero are registered and never high for more than one consecutive cycle.

## Test plan
- mult, A=0xFFFFFFFD (-3), B=5:
  - Busy high for 33 cycles.
  - Done on cycle 34 with HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu, A=B=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001.
- mult, A=0x80000000, B=0x80000000: HI=0x40000000, LO=0.
- div:
  - A=-7, B=2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu, A=0x12345678, B=0: Done on cycle 34 with DivByZero=1, HI=0x12345678, LO=0xFFFFFFFF.
- Busy/write rules:
  - A second Start at cycle 5 of an op is ignored.
  - mthi while Busy is ignored; mthi 0xA5A5A5A5 in IDLE appears on HI next cycle.
  - Start on the Done cycle runs a second op correctly.
- Rst asserted at cycle 10 of a mult:
  - Next cycle has HI=LO=0, Busy=0, and no Done pulse.
  - A following multu 3*4 gives LO=12, HI=0 after 34 cycles.
